// File: rtl/temp_ctrl_pkg.sv
// Shared widths, menu mode encodings and saturating step helpers for the
// temperature setpoint controller.
package temp_ctrl_pkg;

  localparam int TEMP_W = 7;
  localparam int HYST_W = 4;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_EDIT_SP = 2'd1,
    MODE_EDIT_HY = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Done in 8 bits so neither 127+1 nor 0-1 can wrap before the clamp.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] hi);
    return (v >= hi) ? hi : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec8(input logic [7:0] v, input logic [7:0] lo);
    return (v <= lo) ? lo : v - 8'd1;
  endfunction

endpackage

// File: rtl/temp_setpoint_ctrl_key_edge_pri.sv
// Rising-edge detector for the three key pulses with fixed priority
// key1 > key2 > key3; the output is one-hot {k1,k2,k3} or zero.
module key_edge_pri (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1_in,
  input  logic       key2_in,
  input  logic       key3_in,
  output logic [2:0] rise
);

  logic [2:0] key_q;
  logic [2:0] key_d;
  logic [2:0] raw_rise;

  always_comb begin
    key_d    = {key1_in, key2_in, key3_in};
    raw_rise = key_d & ~key_q;
    rise     = 3'b000;
    // Lower-priority rises in the same clock are dropped, not deferred.
    if (raw_rise[2])      rise = 3'b100;
    else if (raw_rise[1]) rise = 3'b010;
    else if (raw_rise[0]) rise = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) key_q <= 3'b000;
    else     key_q <= key_d;
  end

endmodule

// File: rtl/temp_setpoint_ctrl.sv
// Menu FSM editing setpoint and hysteresis, edit timeout, hysteresis
// thermostat and display mux. The mode output is the FSM state itself.
module temp_setpoint_ctrl
  import temp_ctrl_pkg::*;
#(
  parameter int          SP_MIN       = 10,
  parameter int          SP_MAX       = 90,
  parameter int          SP_DEFAULT   = 25,
  parameter int          HYST_MAX     = 9,
  parameter int          HYST_DEFAULT = 2,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key1_in,
  input  logic              key2_in,
  input  logic              key3_in,
  input  logic [TEMP_W-1:0] temp_in,
  output logic [TEMP_W-1:0] setpoint,
  output logic [HYST_W-1:0] hyst,
  output logic [1:0]        mode,
  output logic [TEMP_W-1:0] disp_val,
  output logic              heat_on,
  output logic              commit,
  output logic              timeout
);

  logic [2:0] rise;
  logic       k1, k2, k3, any_rise;

  key_edge_pri u_key_edge_pri (
    .clk     (clk),
    .rst     (rst),
    .key1_in (key1_in),
    .key2_in (key2_in),
    .key3_in (key3_in),
    .rise    (rise)
  );

  assign k1       = rise[2];
  assign k2       = rise[1];
  assign k3       = rise[0];
  assign any_rise = |rise;

  mode_e             mode_q, mode_d;
  logic [TEMP_W-1:0] setpoint_q, setpoint_d;
  logic [HYST_W-1:0] hyst_q, hyst_d;
  logic [TEMP_W-1:0] sp_edit_q, sp_edit_d;
  logic [HYST_W-1:0] hy_edit_q, hy_edit_d;
  logic [23:0]       timer_q, timer_d;
  logic              commit_q, commit_d;
  logic              timeout_q, timeout_d;
  logic              heat_q, heat_d;
  logic [TEMP_W-1:0] disp_q, disp_d;

  logic [7:0] temp_w, sp_w, hy_w, sp_e_w, hy_e_w;

  always_comb begin
    sp_e_w = {1'b0, sp_edit_q};
    hy_e_w = {4'b0, hy_edit_q};
  end

  // Menu FSM, shadow editing and edit timeout
  always_comb begin
    mode_d     = mode_q;
    setpoint_d = setpoint_q;
    hyst_d     = hyst_q;
    sp_edit_d  = sp_edit_q;
    hy_edit_d  = hy_edit_q;
    timer_d    = timer_q;
    commit_d   = 1'b0;
    timeout_d  = 1'b0;

    case (mode_q)
      MODE_RUN: begin
        timer_d = 24'd0;
        if (k1) begin
          mode_d    = MODE_EDIT_SP;
          sp_edit_d = setpoint_q;
          hy_edit_d = hyst_q;
        end
      end

      MODE_EDIT_SP: begin
        if (any_rise) begin
          timer_d = 24'd0;
          if (k1)      mode_d    = MODE_EDIT_HY;
          else if (k2) sp_edit_d = TEMP_W'(sat_inc8(sp_e_w, 8'(SP_MAX)));
          else         sp_edit_d = TEMP_W'(sat_dec8(sp_e_w, 8'(SP_MIN)));
        end else if (timer_q == TIMEOUT_CYC - 24'd1) begin
          mode_d    = MODE_RUN;
          timeout_d = 1'b1;
          timer_d   = 24'd0;
          sp_edit_d = setpoint_q;
          hy_edit_d = hyst_q;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end

      MODE_EDIT_HY: begin
        if (any_rise) begin
          timer_d = 24'd0;
          if (k1) begin
            mode_d     = MODE_RUN;
            setpoint_d = sp_edit_q;
            hyst_d     = hy_edit_q;
            commit_d   = 1'b1;
          end else if (k2) begin
            hy_edit_d = HYST_W'(sat_inc8(hy_e_w, 8'(HYST_MAX)));
          end else if (k3) begin
            hy_edit_d = HYST_W'(sat_dec8(hy_e_w, 8'd0));
          end
        end else if (timer_q == TIMEOUT_CYC - 24'd1) begin
          mode_d    = MODE_RUN;
          timeout_d = 1'b1;
          timer_d   = 24'd0;
          sp_edit_d = setpoint_q;
          hy_edit_d = hyst_q;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end

      default: begin
        mode_d  = MODE_RUN;
        timer_d = 24'd0;
      end
    endcase
  end

  // Thermostat always follows the committed values, never the shadows
  always_comb begin
    temp_w = {1'b0, temp_in};
    sp_w   = {1'b0, setpoint_q};
    hy_w   = {4'b0, hyst_q};
    heat_d = heat_q;
    if (temp_w + hy_w < sp_w)  heat_d = 1'b1;
    else if (temp_w >= sp_w)   heat_d = 1'b0;
  end

  always_comb begin
    case (mode_q)
      MODE_EDIT_SP: disp_d = sp_edit_q;
      MODE_EDIT_HY: disp_d = {3'b000, hy_edit_q};
      default:      disp_d = temp_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_RUN;
      setpoint_q <= TEMP_W'(SP_DEFAULT);
      hyst_q     <= HYST_W'(HYST_DEFAULT);
      sp_edit_q  <= TEMP_W'(SP_DEFAULT);
      hy_edit_q  <= HYST_W'(HYST_DEFAULT);
      timer_q    <= 24'd0;
      commit_q   <= 1'b0;
      timeout_q  <= 1'b0;
      heat_q     <= 1'b0;
      disp_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      setpoint_q <= setpoint_d;
      hyst_q     <= hyst_d;
      sp_edit_q  <= sp_edit_d;
      hy_edit_q  <= hy_edit_d;
      timer_q    <= timer_d;
      commit_q   <= commit_d;
      timeout_q  <= timeout_d;
      heat_q     <= heat_d;
      disp_q     <= disp_d;
    end
  end

  assign setpoint = setpoint_q;
  assign hyst     = hyst_q;
  assign mode     = mode_q;
  assign disp_val = disp_q;
  assign heat_on  = heat_q;
  assign commit   = commit_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_temp_setpoint_ctrl.sv
// Directed bench for temp_setpoint_ctrl: menu walk, saturation, timeout,
// key priority, thermostat hysteresis and reset mid-edit.
module tb_temp_setpoint_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key1_in, key2_in, key3_in;
  logic [6:0] temp_in;
  logic [6:0] setpoint;
  logic [3:0] hyst;
  logic [1:0] mode;
  logic [6:0] disp_val;
  logic       heat_on, commit, timeout;

  int checks = 0;
  int errors = 0;
  int n_commit = 0;
  int n_timeout = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  temp_setpoint_ctrl #(.TIMEOUT_CYC(24'd50)) dut (
    .clk      (clk),
    .rst      (rst),
    .key1_in  (key1_in),
    .key2_in  (key2_in),
    .key3_in  (key3_in),
    .temp_in  (temp_in),
    .setpoint (setpoint),
    .hyst     (hyst),
    .mode     (mode),
    .disp_val (disp_val),
    .heat_on  (heat_on),
    .commit   (commit),
    .timeout  (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are read 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int k, input int n);
    if (k == 1) key1_in = 1'b1;
    if (k == 2) key2_in = 1'b1;
    if (k == 3) key3_in = 1'b1;
    tick(n);
    key1_in = 1'b0;
    key2_in = 1'b0;
    key3_in = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Scoreboard: each commit pulse pops the committed {setpoint,hyst} expected.
  always @(negedge clk) begin
    if (commit === 1'b1) begin
      n_commit++;
      chk("commit_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("commit_val", {21'd0, setpoint, hyst}, {21'd0, exp_q.pop_front()});
    end
    if (timeout === 1'b1) n_timeout++;
  end

  initial begin
    rst = 1'b1; key1_in = 1'b0; key2_in = 1'b0; key3_in = 1'b0; temp_in = 7'd20;
    tick(2);
    chk("rst_setpoint", setpoint, 25);
    chk("rst_hyst", hyst, 2);
    chk("rst_mode", mode, 0);
    chk("rst_disp", disp_val, 0);
    chk("rst_heat", heat_on, 0);
    chk("rst_commit", commit, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    tick(1);
    chk("run_disp_temp", disp_val, 20);
    chk("first_heat", heat_on, 1);

    // Menu walk with multi-clock pulses
    press(1, 5);
    chk("walk_mode1", mode, 1);
    chk("walk_disp_sp", disp_val, 25);
    repeat (3) press(2, 3);
    chk("walk_sp28", disp_val, 28);
    press(1, 4);
    chk("walk_mode2", mode, 2);
    chk("walk_disp_hy", disp_val, 2);
    press(3, 2);
    chk("walk_hy1", disp_val, 1);
    exp_q.push_back({7'd28, 4'd1});
    key1_in = 1'b1;
    tick(1);
    chk("commit_pulse", commit, 1);
    chk("commit_sp", setpoint, 28);
    chk("commit_hy", hyst, 1);
    chk("walk_mode0", mode, 0);
    tick(1);
    chk("commit_one_clk", commit, 0);
    key1_in = 1'b0;
    tick(2);

    // Saturation at both ends of both ranges
    do_reset();
    chk("rst2_setpoint", setpoint, 25);
    press(1, 2);
    repeat (70) press(2, 2);
    chk("sp_sat_max", disp_val, 90);
    chk("sp_sat_mode", mode, 1);
    repeat (85) press(3, 1);
    chk("sp_sat_min", disp_val, 10);
    press(1, 1);
    chk("hy_mode", mode, 2);
    chk("hy_start", disp_val, 2);
    repeat (5) press(3, 3);
    chk("hy_sat_zero", disp_val, 0);
    repeat (12) press(2, 1);
    chk("hy_sat_max", disp_val, 9);
    exp_q.push_back({7'd10, 4'd9});
    press(1, 1);
    chk("sat_commit_sp", setpoint, 10);
    chk("sat_commit_hy", hyst, 9);
    chk("heat_off_low_sp", heat_on, 0);

    // Edit timeout after 50 idle clocks
    do_reset();
    key1_in = 1'b1; tick(1); key1_in = 1'b0;
    key2_in = 1'b1; tick(1); key2_in = 1'b0;
    tick(49);
    chk("to_not_yet", timeout, 0);
    chk("to_still_edit", mode, 1);
    chk("to_disp26", disp_val, 26);
    tick(1);
    chk("to_pulse", timeout, 1);
    chk("to_mode_run", mode, 0);
    chk("to_sp_kept", setpoint, 25);
    chk("to_no_commit", commit, 0);
    tick(1);
    chk("to_one_clk", timeout, 0);
    chk("to_disp_temp", disp_val, 20);

    // Simultaneous key1+key2, then key rise on the timeout clock
    key1_in = 1'b1; key2_in = 1'b1;
    tick(1);
    chk("sim_mode", mode, 1);
    key1_in = 1'b0; key2_in = 1'b0;
    tick(1);
    chk("sim_k2_dropped", disp_val, 25);
    tick(48);
    key2_in = 1'b1;
    tick(1);
    chk("key_beats_to", timeout, 0);
    chk("key_beats_to_mode", mode, 1);
    key2_in = 1'b0;
    tick(1);
    chk("key_beats_to_sp", disp_val, 26);
    exp_q.push_back({7'd26, 4'd2});
    press(1, 1);
    press(1, 1);
    chk("sim_commit_sp", setpoint, 26);

    // Thermostat sweep and committed values used while editing
    do_reset();
    temp_in = 7'd20; tick(2);
    chk("th_20", heat_on, 1);
    temp_in = 7'd25; tick(1);
    chk("th_25", heat_on, 0);
    temp_in = 7'd23; tick(2);
    chk("th_23_hold", heat_on, 0);
    temp_in = 7'd22; tick(1);
    chk("th_22", heat_on, 1);
    press(1, 1);
    repeat (5) press(2, 1);
    chk("th_edit_disp", disp_val, 30);
    temp_in = 7'd26; tick(2);
    chk("th_uses_committed", heat_on, 0);

    // Reset mid-edit
    rst = 1'b1;
    tick(1);
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_sp", setpoint, 25);
    chk("mid_rst_hy", hyst, 2);
    chk("mid_rst_disp", disp_val, 0);
    chk("mid_rst_heat", heat_on, 0);
    chk("mid_rst_commit", commit, 0);
    chk("mid_rst_timeout", timeout, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_disp", disp_val, 26);
    press(1, 1);
    chk("post_rst_edit", disp_val, 25);

    chk("commit_count", n_commit, 3);
    chk("timeout_count", n_timeout, 1);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
